crossbar_pkt_arbiter: RTL and testbench

Packet-level arbiter that drives the four `fifo_sel_bits_k` select vectors of the 4x4 AXI-Stream cross bar. Each rx port raises a request naming a destination FIFO. Each FIFO is granted to one rx port at a time, chosen round-robin, and the grant is held until the last beat of the packet is accepted. It sits between the rx framing logic and the bus cross bar, and monitors the cross-bar FIFO-side handshake to detect packet end.

---
 rtl/crossbar_pkt_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_crossbar_pkt_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_pkt_arbiter.sv
// Round-robin packet arbiter driving the four FIFO select vectors of the 4x4 AXI-Stream cross bar.
// Optional idle-beat watchdog release is compiled in with `define ARB_TIMEOUT_EN.
module crossbar_pkt_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       glb_clk,
    input  logic       glb_reset,
    input  logic       rx_req_0,
    input  logic       rx_req_1,
    input  logic       rx_req_2,
    input  logic       rx_req_3,
    input  logic [1:0] rx_dest_0,
    input  logic [1:0] rx_dest_1,
    input  logic [1:0] rx_dest_2,
    input  logic [1:0] rx_dest_3,
    output logic       rx_gnt_0,
    output logic       rx_gnt_1,
    output logic       rx_gnt_2,
    output logic       rx_gnt_3,
    input  logic       fifo_mon_0_tvalid,
    input  logic       fifo_mon_0_tready,
    input  logic       fifo_mon_0_tlast,
    input  logic       fifo_mon_1_tvalid,
    input  logic       fifo_mon_1_tready,
    input  logic       fifo_mon_1_tlast,
    input  logic       fifo_mon_2_tvalid,
    input  logic       fifo_mon_2_tready,
    input  logic       fifo_mon_2_tlast,
    input  logic       fifo_mon_3_tvalid,
    input  logic       fifo_mon_3_tready,
    input  logic       fifo_mon_3_tlast,
    output logic [3:0] fifo_sel_bits_0,
    output logic [3:0] fifo_sel_bits_1,
    output logic [3:0] fifo_sel_bits_2,
    output logic [3:0] fifo_sel_bits_3,
    output logic [3:0] fifo_busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic [3:0] fifo_timeout
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [3:0] w_req;
    logic [3:0] w_beat;
    logic [3:0] w_last;
    logic [1:0] w_dest [4];

    assign w_req  = {rx_req_3, rx_req_2, rx_req_1, rx_req_0};
    assign w_beat = {fifo_mon_3_tvalid & fifo_mon_3_tready, fifo_mon_2_tvalid & fifo_mon_2_tready,
                     fifo_mon_1_tvalid & fifo_mon_1_tready, fifo_mon_0_tvalid & fifo_mon_0_tready};
    assign w_last = {fifo_mon_3_tlast, fifo_mon_2_tlast, fifo_mon_1_tlast, fifo_mon_0_tlast};
    assign w_dest[0] = rx_dest_0;
    assign w_dest[1] = rx_dest_1;
    assign w_dest[2] = rx_dest_2;
    assign w_dest[3] = rx_dest_3;

    logic [1:0] r_state [4];
    logic [1:0] r_owner [4];
    logic [1:0] r_rr    [4];
    logic [3:0] r_sel   [4];
    logic [3:0] r_gnt;
    logic [3:0] r_busy;

    logic [1:0] w_state_n [4];
    logic [1:0] w_owner_n [4];
    logic [1:0] w_rr_n    [4];
    logic [3:0] w_sel_n   [4];
    logic [3:0] w_gnt_n;
    logic [3:0] w_busy_n;
    logic       w_found   [4];
    logic [1:0] w_pick    [4];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt   [4];
    logic [CNT_W-1:0] w_cnt_n [4];
    logic [3:0]       r_to;
    logic [3:0]       w_to_n;
`else
    // Watchdog compiled out: TIMEOUT_CYCLES only has to lie in its legal range.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
    end
`endif

    // Candidates already owning another FIFO are excluded, so two FIFOs never pick the same rx.
    always_comb begin : p_pick
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_found[k] = 1'b0;
            w_pick[k]  = r_rr[k];
            for (int i = 0; i < 4; i++) begin
                idx = r_rr[k] + 2'(i);
                if (!w_found[k] && w_req[idx] && (w_dest[idx] == 2'(k)) && !r_gnt[idx]) begin
                    w_found[k] = 1'b1;
                    w_pick[k]  = idx;
                end
            end
        end
    end

    always_comb begin : p_next
        logic rel;
        rel      = 1'b0;
        w_gnt_n  = 4'b0000;
        w_busy_n = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        w_to_n   = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            w_state_n[k] = r_state[k];
            w_owner_n[k] = r_owner[k];
            w_rr_n[k]    = r_rr[k];
            w_sel_n[k]   = r_sel[k];
`ifdef ARB_TIMEOUT_EN
            w_cnt_n[k]   = r_cnt[k];
`endif
            rel = 1'b0;
            case (r_state[k])
                S_IDLE: begin
                    if (w_found[k]) begin
                        w_state_n[k] = S_GRANT;
                        w_owner_n[k] = w_pick[k];
                        w_sel_n[k]   = 4'b0001 << w_pick[k];
`ifdef ARB_TIMEOUT_EN
                        w_cnt_n[k]   = '0;
`endif
                    end
                end
                S_GRANT: begin
                    rel = w_beat[k] & w_last[k];
`ifdef ARB_TIMEOUT_EN
                    if (w_beat[k]) begin
                        w_cnt_n[k] = '0;
                    end else if (r_cnt[k] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rel       = 1'b1;
                        w_to_n[k] = 1'b1;
                    end else begin
                        w_cnt_n[k] = r_cnt[k] + CNT_W'(1);
                    end
`endif
                    if (rel) begin
                        w_state_n[k] = S_GAP;
                        w_sel_n[k]   = 4'b0000;
                        w_rr_n[k]    = r_owner[k] + 2'd1;
                    end
                end
                default: begin
                    // One dead cycle so the cross-bar select register settles before re-grant.
                    w_state_n[k] = S_IDLE;
                end
            endcase
            w_gnt_n     = w_gnt_n | w_sel_n[k];
            w_busy_n[k] = |w_sel_n[k];
        end
    end

    always_ff @(posedge glb_clk) begin
        if (glb_reset) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= S_IDLE;
                r_owner[k] <= 2'd0;
                r_rr[k]    <= 2'd0;
                r_sel[k]   <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
                r_cnt[k]   <= '0;
`endif
            end
            r_gnt  <= 4'b0000;
            r_busy <= 4'b0000;
`ifdef ARB_TIMEOUT_EN
            r_to   <= 4'b0000;
`endif
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= w_state_n[k];
                r_owner[k] <= w_owner_n[k];
                r_rr[k]    <= w_rr_n[k];
                r_sel[k]   <= w_sel_n[k];
`ifdef ARB_TIMEOUT_EN
                r_cnt[k]   <= w_cnt_n[k];
`endif
            end
            r_gnt  <= w_gnt_n;
            r_busy <= w_busy_n;
`ifdef ARB_TIMEOUT_EN
            r_to   <= w_to_n;
`endif
        end
    end

    assign rx_gnt_0        = r_gnt[0];
    assign rx_gnt_1        = r_gnt[1];
    assign rx_gnt_2        = r_gnt[2];
    assign rx_gnt_3        = r_gnt[3];
    assign fifo_sel_bits_0 = r_sel[0];
    assign fifo_sel_bits_1 = r_sel[1];
    assign fifo_sel_bits_2 = r_sel[2];
    assign fifo_sel_bits_3 = r_sel[3];
    assign fifo_busy       = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign fifo_timeout    = r_to;
`endif

endmodule

// File: tb/tb_crossbar_pkt_arbiter.sv
// Bench for crossbar_pkt_arbiter: directed scenarios plus randomized traffic against a reference model.
// Watchdog scenario is built when ARB_TIMEOUT_EN is defined.
module tb_crossbar_pkt_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic       glb_clk = 1'b0;
    logic       glb_reset;
    logic       rq [4];
    logic [1:0] ds [4];
    logic       tv [4];
    logic       tr [4];
    logic       tl [4];
    logic       g0, g1, g2, g3;
    logic [3:0] s0, s1, s2, s3;
    logic [3:0] busy;
    logic [3:0] to;
    logic [27:0] obs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner per FIFO (-1 = free), round-robin start, dead cycles left, idle-beat count.
    int         m_own  [4];
    int         m_rr   [4];
    int         m_cool [4];
    int         m_wd   [4];
    logic [3:0] m_to;

    always #5 glb_clk = ~glb_clk;

    crossbar_pkt_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .glb_clk(glb_clk), .glb_reset(glb_reset),
        .rx_req_0(rq[0]), .rx_req_1(rq[1]), .rx_req_2(rq[2]), .rx_req_3(rq[3]),
        .rx_dest_0(ds[0]), .rx_dest_1(ds[1]), .rx_dest_2(ds[2]), .rx_dest_3(ds[3]),
        .rx_gnt_0(g0), .rx_gnt_1(g1), .rx_gnt_2(g2), .rx_gnt_3(g3),
        .fifo_mon_0_tvalid(tv[0]), .fifo_mon_0_tready(tr[0]), .fifo_mon_0_tlast(tl[0]),
        .fifo_mon_1_tvalid(tv[1]), .fifo_mon_1_tready(tr[1]), .fifo_mon_1_tlast(tl[1]),
        .fifo_mon_2_tvalid(tv[2]), .fifo_mon_2_tready(tr[2]), .fifo_mon_2_tlast(tl[2]),
        .fifo_mon_3_tvalid(tv[3]), .fifo_mon_3_tready(tr[3]), .fifo_mon_3_tlast(tl[3]),
        .fifo_sel_bits_0(s0), .fifo_sel_bits_1(s1), .fifo_sel_bits_2(s2), .fifo_sel_bits_3(s3),
        .fifo_busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .fifo_timeout(to)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    assign to = 4'b0000;
`endif
    assign obs = {s3, s2, s1, s0, g3, g2, g1, g0, busy, to};

    function automatic logic [3:0] m_gnt();
        logic [3:0] g;
        g = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (m_own[k] >= 0) g[m_own[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic [27:0] exp_obs();
        logic [3:0] sel [4];
        logic [3:0] b;
        for (int k = 0; k < 4; k++) begin
            sel[k] = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
            b[k]   = (m_own[k] >= 0);
        end
        return {sel[3], sel[2], sel[1], sel[0], m_gnt(), b, m_to};
    endfunction

    task automatic model_step();
        logic [3:0] gold;
        logic       rel;
        int         j;
        gold = m_gnt();
        if (glb_reset) begin
            for (int k = 0; k < 4; k++) begin
                m_own[k] = -1; m_rr[k] = 0; m_cool[k] = 0; m_wd[k] = 0;
            end
            m_to = 4'b0000;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            m_to[k] = 1'b0;
            if (m_own[k] >= 0) begin
                rel = tv[k] && tr[k] && tl[k];
`ifdef ARB_TIMEOUT_EN
                if (tv[k] && tr[k]) m_wd[k] = 0;
                else begin
                    m_wd[k]++;
                    if (m_wd[k] >= TO) begin rel = 1'b1; m_to[k] = 1'b1; end
                end
`endif
                if (rel) begin
                    m_rr[k]   = (m_own[k] + 1) % 4;
                    m_own[k]  = -1;
                    m_cool[k] = 1;
                end
            end else if (m_cool[k] > 0) begin
                m_cool[k]--;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    j = (m_rr[k] + i) % 4;
                    if (rq[j] && int'(ds[j]) == k && !gold[j]) begin
                        m_own[k] = j; m_wd[k] = 0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge glb_clk);
        #1;
    endtask

    task automatic idle_all();
        for (int j = 0; j < 4; j++) begin
            rq[j] = 1'b0; ds[j] = 2'd0; tv[j] = 1'b0; tr[j] = 1'b0; tl[j] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        glb_reset = 1'b1;
        cyc();
        glb_reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        glb_reset = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if (obs !== 28'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 28'h0);
        end
        glb_reset = 1'b0;
        cyc();
        n_vec++;
        if (obs !== exp_obs()) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", obs, exp_obs());
        end
    endtask

    task automatic test_single();
        do_reset();
        rq[2] = 1'b1; ds[2] = 2'd1;
        cyc();
        n_vec++;
        if ({s1, g2} !== {4'b0100, 1'b1}) begin
            n_err++; $display("FAIL single_grant: got sel1=%b gnt2=%b want sel1=0100 gnt2=1", s1, g2);
        end
        tv[1] = 1'b1; tr[1] = 1'b1; tl[1] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) tl[1] = 1'b1;
            cyc();
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++; $display("FAIL single_beat%0d: got %h want %h", b, obs, exp_obs());
            end
        end
        n_vec++;
        if ({s1, g2, busy} !== 9'b0) begin
            n_err++; $display("FAIL single_release: got sel1=%b gnt2=%b busy=%b want all 0", s1, g2, busy);
        end
        idle_all();
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++; $display("FAIL single_after%0d: got %h want %h", c, obs, exp_obs());
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        logic [3:0] want  [5];
        logic [3:0] prev;
        int         n;
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000; want[4] = 4'b0001;
        do_reset();
        for (int j = 0; j < 4; j++) begin rq[j] = 1'b1; ds[j] = 2'd0; end
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1;
        prev = 4'b0000;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            cyc();
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++; $display("FAIL rr_model cyc %0d: got %h want %h", c, obs, exp_obs());
            end
            if (s0 !== 4'b0000 && prev === 4'b0000) begin
                order[n] = s0;
                n++;
            end
            prev = s0;
        end
        n_vec++;
        if (n != 5) begin
            n_err++; $display("FAIL rr_count: got %0d grants want 5", n);
        end
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (order[i] !== want[i]) begin
                n_err++; $display("FAIL rr_order%0d: got %b want %b", i, order[i], want[i]);
            end
        end
        idle_all();
    endtask

    task automatic test_parallel();
        do_reset();
        rq[0] = 1'b1; ds[0] = 2'd3;
        rq[3] = 1'b1; ds[3] = 2'd0;
        cyc();
        n_vec++;
        if ({busy, s3, s0, g3, g2, g1, g0} !== {4'b1001, 4'b0001, 4'b1000, 4'b1001}) begin
            n_err++; $display("FAIL parallel_grant: got busy=%b sel3=%b sel0=%b gnt=%b%b%b%b want 1001 0001 1000 1001",
                              busy, s3, s0, g3, g2, g1, g0);
        end
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1;
        tv[3] = 1'b1; tr[3] = 1'b1; tl[3] = 1'b1;
        cyc();
        n_vec++;
        if (busy !== 4'b0000) begin
            n_err++; $display("FAIL parallel_release: got busy=%b want 0000", busy);
        end
        idle_all();
        cyc();
    endtask

    task automatic test_backpressure();
        do_reset();
        rq[1] = 1'b1; ds[1] = 2'd2;
        cyc();
        tv[2] = 1'b1; tl[2] = 1'b1; tr[2] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) rq[1] = 1'b0;
            cyc();
            n_vec++;
            if ({g1, s2} !== {1'b1, 4'b0010} || obs !== exp_obs()) begin
                n_err++; $display("FAIL bp_hold cyc %0d: got %h want %h", c, obs, exp_obs());
            end
        end
        tr[2] = 1'b1;
        cyc();
        n_vec++;
        if ({g1, s2} !== 5'b0) begin
            n_err++; $display("FAIL bp_release: got gnt1=%b sel2=%b want 0 0000", g1, s2);
        end
        idle_all();
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rq[1] = 1'b1; ds[1] = 2'd0;
        cyc();
        tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1;
        cyc();
        idle_all();
        cyc();
        cyc();
        rq[3] = 1'b1; ds[3] = 2'd0;
        cyc();
        n_vec++;
        if (s0 !== 4'b1000) begin
            n_err++; $display("FAIL rstmid_pre: got sel0=%b want 1000", s0);
        end
        glb_reset = 1'b1;
        cyc();
        glb_reset = 1'b0;
        n_vec++;
        if (obs !== 28'h0) begin
            n_err++; $display("FAIL rstmid_clear: got %h want %h", obs, 28'h0);
        end
        for (int j = 0; j < 4; j++) begin rq[j] = 1'b1; ds[j] = 2'd0; end
        cyc();
        n_vec++;
        if (s0 !== 4'b0001 || obs !== exp_obs()) begin
            n_err++; $display("FAIL rstmid_first: got %h want %h", obs, exp_obs());
        end
        idle_all();
    endtask

    task automatic test_random();
        logic [3:0] mg;
        logic [3:0] pg;
        int         shown;
        shown = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            mg = m_gnt();
            for (int j = 0; j < 4; j++) begin
                if (!rq[j] && !mg[j] && $urandom_range(0, 3) == 0) begin
                    rq[j] = 1'b1; ds[j] = 2'($urandom_range(0, 3));
                end else if (rq[j] && mg[j] && $urandom_range(0, 31) == 0) begin
                    rq[j] = 1'b0;
                end
                tv[j] = 1'($urandom_range(0, 1));
                tr[j] = ($urandom_range(0, 3) != 0);
                tl[j] = ($urandom_range(0, 3) == 0);
            end
            glb_reset = ($urandom_range(0, 499) == 0);
            pg = m_gnt();
            cyc();
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++;
                if (shown < 10) $display("FAIL random cyc %0d: got %h want %h", c, obs, exp_obs());
                shown++;
            end
            mg = m_gnt();
            for (int j = 0; j < 4; j++)
                if (pg[j] && !mg[j]) rq[j] = 1'b0;
        end
        glb_reset = 1'b0;
        idle_all();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_watchdog();
        int n;
        do_reset();
        rq[0] = 1'b1; ds[0] = 2'd1;
        cyc();
        n = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            n++;
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++; $display("FAIL wd_model cyc %0d: got %h want %h", c, obs, exp_obs());
            end
            if (to[1] === 1'b1) break;
        end
        n_vec++;
        if (n != 8 || s1 !== 4'b0000) begin
            n_err++; $display("FAIL wd_expire: got %0d cycles sel1=%b want 8 cycles sel1=0000", n, s1);
        end
        rq[0] = 1'b0;
        cyc();
        rq[0] = 1'b1;
        for (int c = 0; c < 10 && s1 === 4'b0000; c++) cyc();
        n = 0;
        for (int c = 0; c < 40; c++) begin
            tv[1] = (n == 6); tr[1] = (n == 6);
            cyc();
            n++;
            n_vec++;
            if (obs !== exp_obs()) begin
                n_err++; $display("FAIL wd_restart_model cyc %0d: got %h want %h", c, obs, exp_obs());
            end
            if (to[1] === 1'b1) break;
        end
        n_vec++;
        if (n != 15) begin
            n_err++; $display("FAIL wd_restart: got %0d cycles want 15", n);
        end
        idle_all();
        cyc();
    endtask
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_own[k] = -1; m_rr[k] = 0; m_cool[k] = 0; m_wd[k] = 0;
        end
        m_to = 4'b0000;
        glb_reset = 1'b1;
        idle_all();
        test_reset();
        test_single();
        test_round_robin();
        test_parallel();
        test_backpressure();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_watchdog();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got no finish want finish before 1000000");
        $fatal(1);
    end

endmodule
